// File: rtl/ex_mem_if.sv
// EX/MEM stage bus: EX-side request fields in, registered MEM-side fields,
// forwarding taps and stall-watchdog status out.
interface ex_mem_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int STALL_W    = 6,
  parameter int CNT_W      = 8
);
  logic [STALL_W-1:0]    stall;
  logic                  flush;
  logic                  valid_i;
  logic [ADDR_W-1:0]     mem_addr_i;
  logic                  r_mem_i;
  logic                  w_mem_i;
  logic [DATA_W-1:0]     mem_wdata_i;
  logic [DATA_W-1:0]     w_data_i;
  logic                  w_reg_i;
  logic [REG_ADDR_W-1:0] w_reg_addr_i;

  logic                  valid_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic                  r_mem_o;
  logic                  w_mem_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W-1:0]     w_data_o;
  logic                  w_reg_o;
  logic [REG_ADDR_W-1:0] w_reg_addr_o;
  logic                  fwd_we;
  logic [REG_ADDR_W-1:0] fwd_addr;
  logic [DATA_W-1:0]     fwd_data;
  logic [CNT_W-1:0]      hold_cnt;
  logic                  hold_timeout;

  modport master (
    output stall, flush, valid_i, mem_addr_i, r_mem_i, w_mem_i,
           mem_wdata_i, w_data_i, w_reg_i, w_reg_addr_i,
    input  valid_o, mem_addr_o, r_mem_o, w_mem_o, mem_wdata_o, w_data_o,
           w_reg_o, w_reg_addr_o, fwd_we, fwd_addr, fwd_data,
           hold_cnt, hold_timeout
  );

  modport slave (
    input  stall, flush, valid_i, mem_addr_i, r_mem_i, w_mem_i,
           mem_wdata_i, w_data_i, w_reg_i, w_reg_addr_i,
    output valid_o, mem_addr_o, r_mem_o, w_mem_o, mem_wdata_o, w_data_o,
           w_reg_o, w_reg_addr_o, fwd_we, fwd_addr, fwd_data,
           hold_cnt, hold_timeout
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Parametrised EX/MEM pipeline register with valid bit, flush, hold,
// forwarding taps and a saturating stall-watchdog counter.
module ex_mem_stage #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter int                REG_ADDR_W = 4,
  parameter int                STALL_W    = 6,
  parameter int                STAGE_IDX  = 3,
  parameter logic [ADDR_W-1:0] BAD_ADDR   = {ADDR_W{1'b1}},
  parameter int                CNT_W      = 8,
  parameter int                TIMEOUT    = 64
) (
  input logic    clk,
  input logic    rst,
  ex_mem_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  r_mem;
    logic                  w_mem;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     w_data;
    logic                  w_reg;
    logic [REG_ADDR_W-1:0] w_reg_addr;
  } entry_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = TIMEOUT[CNT_W-1:0];

  function automatic entry_t bubble();
    entry_t e;
    e            = '0;
    e.mem_addr   = BAD_ADDR;
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  entry_t           entry_q, entry_d, load_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             s, n;

  // Bits beyond the stall bus width read as 0, so a top-of-bus stage never sees n=1.
  always_comb begin
    s = 1'b0;
    n = 1'b0;
    for (int i = 0; i < STALL_W; i++) begin
      if (i == STAGE_IDX)     s = bus.stall[i];
      if (i == STAGE_IDX + 1) n = bus.stall[i];
    end
  end

  always_comb begin
    load_e            = '0;
    load_e.valid      = bus.valid_i;
    load_e.mem_addr   = bus.mem_addr_i;
    load_e.r_mem      = bus.r_mem_i;
    load_e.w_mem      = bus.w_mem_i;
    load_e.mem_wdata  = bus.mem_wdata_i;
    load_e.w_data     = bus.w_data_i;
    load_e.w_reg      = bus.w_reg_i;
    load_e.w_reg_addr = bus.w_reg_addr_i;
    // Squashed entries keep their data so debug views still see what EX produced.
    if (!bus.valid_i) begin
      load_e.r_mem    = 1'b0;
      load_e.w_mem    = 1'b0;
      load_e.w_reg    = 1'b0;
      load_e.mem_addr = BAD_ADDR;
    end
  end

  always_comb begin
    entry_d = entry_q;
    cnt_d   = '0;
    if (bus.flush) begin
      entry_d = bubble();
    end else if (s && !n) begin
      entry_d = bubble();
    end else if (s && n) begin
      entry_d = entry_q;
      cnt_d   = sat_inc(cnt_q);
    end else begin
      entry_d = load_e;
    end
    timeout_d = (cnt_d >= TIMEOUT_C);
  end

  // EX -> MEM register boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q   <= bubble();
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      entry_q   <= entry_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.valid_o      = entry_q.valid;
  assign bus.mem_addr_o   = entry_q.mem_addr;
  assign bus.r_mem_o      = entry_q.r_mem;
  assign bus.w_mem_o      = entry_q.w_mem;
  assign bus.mem_wdata_o  = entry_q.mem_wdata;
  assign bus.w_data_o     = entry_q.w_data;
  assign bus.w_reg_o      = entry_q.w_reg;
  assign bus.w_reg_addr_o = entry_q.w_reg_addr;

  // Register 0 is hardwired, so it is never a forwarding source.
  assign bus.fwd_we       = entry_q.valid & entry_q.w_reg & (entry_q.w_reg_addr != '0);
  assign bus.fwd_addr     = entry_q.w_reg_addr;
  assign bus.fwd_data     = entry_q.w_data;

  assign bus.hold_cnt     = cnt_q;
  assign bus.hold_timeout = timeout_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, bubble, hold/watchdog, flush,
// forwarding, pass-through and asynchronous reset scenarios.
module tb_ex_mem_stage;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ex_mem_if #(.DATA_W(16), .ADDR_W(16), .REG_ADDR_W(4), .STALL_W(6), .CNT_W(8)) bus ();

  ex_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] addr, input logic r, input logic w,
                       input logic [15:0] wd, input logic [15:0] d, input logic wr,
                       input logic [3:0] ra);
    bus.valid_i      = v;
    bus.mem_addr_i   = addr;
    bus.r_mem_i      = r;
    bus.w_mem_i      = w;
    bus.mem_wdata_i  = wd;
    bus.w_data_i     = d;
    bus.w_reg_i      = wr;
    bus.w_reg_addr_i = ra;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'($urandom), 1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b1, 4'($urandom));
      bus.stall = 6'($urandom);
      tick();
    end
    n_chk++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.valid_o); end
    n_chk++; if (bus.mem_addr_o !== 16'hFFFF) begin n_fail++; $display("FAIL reset_addr: got %h want ffff", bus.mem_addr_o); end
    n_chk++; if ({bus.r_mem_o, bus.w_mem_o, bus.w_reg_o} !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b want 000", {bus.r_mem_o, bus.w_mem_o, bus.w_reg_o}); end
    n_chk++; if ({bus.hold_cnt, bus.hold_timeout} !== 9'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0b want 0/0", bus.hold_cnt, bus.hold_timeout); end
    n_chk++; if (bus.w_data_o !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.w_data_o); end
    bus.stall = 6'b0;
    drive(1'b1, 16'h0100, 1'b0, 1'b0, 16'h0, 16'h1234, 1'b1, 4'd5);
    rst = 1'b1;
    tick();
    n_chk++; if (bus.w_data_o !== 16'h1234) begin n_fail++; $display("FAIL first_load_data: got %h want 1234", bus.w_data_o); end
    n_chk++; if (bus.fwd_we !== 1'b1) begin n_fail++; $display("FAIL first_load_fwd_we: got %0b want 1", bus.fwd_we); end
    n_chk++; if (bus.fwd_addr !== 4'd5) begin n_fail++; $display("FAIL first_load_fwd_addr: got %0d want 5", bus.fwd_addr); end
    n_chk++; if (bus.fwd_data !== 16'h1234) begin n_fail++; $display("FAIL first_load_fwd_data: got %h want 1234", bus.fwd_data); end
    n_chk++; if (bus.mem_addr_o !== 16'h0100 || bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL first_load_addr: got %h/%0b want 0100/1", bus.mem_addr_o, bus.valid_o); end
  endtask

  task automatic test_bubble();
    bus.stall = 6'b001000;
    drive(1'b1, 16'h0040, 1'b1, 1'b0, 16'h5555, 16'h7777, 1'b1, 4'd3);
    tick();
    n_chk++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %0b want 0", bus.valid_o); end
    n_chk++; if (bus.w_reg_o !== 1'b0 || bus.r_mem_o !== 1'b0) begin n_fail++; $display("FAIL bubble_en: got %0b%0b want 00", bus.w_reg_o, bus.r_mem_o); end
    n_chk++; if (bus.mem_addr_o !== 16'hFFFF) begin n_fail++; $display("FAIL bubble_addr: got %h want ffff", bus.mem_addr_o); end
    n_chk++; if (bus.w_data_o !== 16'h0) begin n_fail++; $display("FAIL bubble_data: got %h want 0", bus.w_data_o); end
    bus.stall = 6'b0;
  endtask

  task automatic test_hold_watchdog();
    bus.stall = 6'b0;
    drive(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'hBEEF, 1'b1, 4'd2);
    tick();
    bus.stall = 6'b011000;
    for (int i = 1; i <= 70; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b1, 16'(i), 16'h1000 + 16'(i), 1'b0, 4'(i));
      tick();
      n_chk++; if (bus.w_data_o !== 16'hBEEF) begin n_fail++; $display("FAIL hold_data[%0d]: got %h want beef", i, bus.w_data_o); end
      n_chk++; if (bus.hold_cnt !== 8'(i)) begin n_fail++; $display("FAIL hold_cnt[%0d]: got %0d want %0d", i, bus.hold_cnt, i); end
      n_chk++; if (bus.hold_timeout !== (i >= 64)) begin n_fail++; $display("FAIL hold_timeout[%0d]: got %0b want %0b", i, bus.hold_timeout, (i >= 64)); end
    end
    bus.stall = 6'b0;
    tick();
    n_chk++; if (bus.hold_cnt !== 8'd0 || bus.hold_timeout !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %0d/%0b want 0/0", bus.hold_cnt, bus.hold_timeout); end
    n_chk++; if (bus.w_data_o !== 16'h1046) begin n_fail++; $display("FAIL hold_release_data: got %h want 1046", bus.w_data_o); end
  endtask

  task automatic test_saturation();
    bus.stall = 6'b011000;
    for (int i = 0; i < 260; i++) tick();
    n_chk++; if (bus.hold_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", bus.hold_cnt); end
    n_chk++; if (bus.hold_timeout !== 1'b1) begin n_fail++; $display("FAIL sat_timeout: got %0b want 1", bus.hold_timeout); end
    bus.stall = 6'b0;
    tick();
  endtask

  task automatic test_flush();
    bus.stall = 6'b0;
    drive(1'b1, 16'h0200, 1'b0, 1'b1, 16'hCAFE, 16'h0042, 1'b0, 4'd0);
    tick();
    n_chk++; if (bus.w_mem_o !== 1'b1 || bus.mem_wdata_o !== 16'hCAFE) begin n_fail++; $display("FAIL flush_setup: got %0b/%h want 1/cafe", bus.w_mem_o, bus.mem_wdata_o); end
    bus.stall = 6'b011000;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_chk++; if (bus.valid_o !== 1'b0 || bus.w_mem_o !== 1'b0) begin n_fail++; $display("FAIL flush_state: got %0b/%0b want 0/0", bus.valid_o, bus.w_mem_o); end
    n_chk++; if (bus.mem_addr_o !== 16'hFFFF || bus.mem_wdata_o !== 16'h0) begin n_fail++; $display("FAIL flush_fields: got %h/%h want ffff/0000", bus.mem_addr_o, bus.mem_wdata_o); end
    n_chk++; if (bus.hold_cnt !== 8'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", bus.hold_cnt); end
    bus.stall = 6'b0;
  endtask

  task automatic test_fwd_r0();
    bus.stall = 6'b0;
    drive(1'b1, 16'h0300, 1'b0, 1'b0, 16'h0, 16'h00AA, 1'b1, 4'd0);
    tick();
    n_chk++; if (bus.fwd_we !== 1'b0 || bus.w_reg_o !== 1'b1) begin n_fail++; $display("FAIL fwd_r0: got we=%0b wreg=%0b want 0/1", bus.fwd_we, bus.w_reg_o); end
    drive(1'b0, 16'h0304, 1'b1, 1'b1, 16'h1111, 16'h00BB, 1'b1, 4'd7);
    tick();
    n_chk++; if (bus.fwd_we !== 1'b0) begin n_fail++; $display("FAIL fwd_invalid: got %0b want 0", bus.fwd_we); end
    n_chk++; if ({bus.r_mem_o, bus.w_mem_o, bus.w_reg_o} !== 3'b000 || bus.mem_addr_o !== 16'hFFFF) begin n_fail++; $display("FAIL squash_ctrl: got %b/%h want 000/ffff", {bus.r_mem_o, bus.w_mem_o, bus.w_reg_o}, bus.mem_addr_o); end
    n_chk++; if (bus.w_data_o !== 16'h00BB || bus.mem_wdata_o !== 16'h1111 || bus.w_reg_addr_o !== 4'd7) begin n_fail++; $display("FAIL squash_data: got %h/%h/%0d want 00bb/1111/7", bus.w_data_o, bus.mem_wdata_o, bus.w_reg_addr_o); end
  endtask

  task automatic test_passthrough();
    bus.stall = 6'b100111;
    drive(1'b1, 16'h0A0A, 1'b1, 1'b1, 16'h3C3C, 16'h5A5A, 1'b1, 4'd9);
    tick();
    n_chk++; if (bus.r_mem_o !== 1'b1 || bus.w_mem_o !== 1'b1) begin n_fail++; $display("FAIL both_mem: got r=%0b w=%0b want 1/1", bus.r_mem_o, bus.w_mem_o); end
    n_chk++; if (bus.mem_addr_o !== 16'h0A0A || bus.valid_o !== 1'b1 || bus.fwd_data !== 16'h5A5A) begin n_fail++; $display("FAIL other_stall_bits: got %h/%0b/%h want 0a0a/1/5a5a", bus.mem_addr_o, bus.valid_o, bus.fwd_data); end
    bus.stall = 6'b0;
  endtask

  task automatic test_async_reset();
    bus.stall = 6'b0;
    drive(1'b1, 16'h0500, 1'b1, 1'b0, 16'h0, 16'h9999, 1'b1, 4'd4);
    tick();
    bus.stall = 6'b011000;
    tick();
    tick();
    n_chk++; if (bus.hold_cnt !== 8'd2 || bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL async_setup: got %0d/%0b want 2/1", bus.hold_cnt, bus.valid_o); end
    #2;
    rst = 1'b0;
    #1;
    n_chk++; if (bus.valid_o !== 1'b0 || bus.mem_addr_o !== 16'hFFFF || bus.r_mem_o !== 1'b0) begin n_fail++; $display("FAIL async_ctrl: got %0b/%h/%0b want 0/ffff/0", bus.valid_o, bus.mem_addr_o, bus.r_mem_o); end
    n_chk++; if (bus.hold_cnt !== 8'd0 || bus.w_data_o !== 16'h0 || bus.fwd_we !== 1'b0) begin n_fail++; $display("FAIL async_data: got %0d/%h/%0b want 0/0000/0", bus.hold_cnt, bus.w_data_o, bus.fwd_we); end
    tick();
    bus.stall = 6'b0;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.flush = 1'b0;
    bus.stall = 6'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 4'd0);
    #2;
    test_reset();
    test_bubble();
    test_hold_watchdog();
    test_saturation();
    test_flush();
    test_fwd_r0();
    test_passthrough();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
